// File: rtl/nucl_ascii_serializer.sv
// nucl_ascii_serializer
//   Turns packed 2-bit nucleotide words (16 per 32-bit word, nucleotide 0 in
//   bits [31:30]) into an ASCII character stream. The stream is truncated to a
//   sequence length that is latched when start is accepted.
//   Build option: define NUCL_FASTA_WRAP_EN to insert 8'h0A after every
//   LINE_LEN nucleotides and after the final nucleotide.
// Ports
//   clk, reset     clock; asynchronous active-low reset
//   start, seq_len begin a sequence of seq_len nucleotides (ignored while busy)
//   in_valid/in_ready/in_data    packed word input
//   out_valid/out_ready/out_char ASCII output; out_last marks the final char
//   busy           sequence in progress
//   done           one-cycle pulse after the final char is accepted
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | emitting nucleotides from the FIFO head
// S_NL   | emitting a line break (wrap build only)
module nucl_ascii_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned LINE_LEN   = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NL} state_t;

  state_t           state, state_nx;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [LEN_W-1:0] len_q, words_needed, words_acc, nucl_cnt;
  logic [3:0]       nib_idx;
  logic             done_q;
  logic             fifo_empty, fifo_full;
  logic             push, pop, nucl_fire, seq_end, start_ok, start_zero;
  logic             nucl_last, seq_complete;
  logic [31:0]      head, head_sh;
  logic [7:0]       nucl_ascii;
`ifdef NUCL_FASTA_WRAP_EN
  localparam logic [LEN_W-1:0] LINE_LAST = LEN_W'(LINE_LEN - 1);
  logic [LEN_W-1:0] line_cnt;
`endif

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head    = mem[rd_ptr[AW-1:0]];
  assign head_sh = head << {nib_idx, 1'b0};

  always_comb begin
    case (head_sh[31:30])
      2'b00:   nucl_ascii = 8'h41;
      2'b01:   nucl_ascii = 8'h43;
      2'b10:   nucl_ascii = 8'h47;
      default: nucl_ascii = 8'h54;
    endcase
  end

  assign nucl_last    = (nucl_cnt == len_q - LEN_W'(1));
  assign seq_complete = (nucl_cnt == len_q);
  assign start_ok     = (state == S_IDLE) && start && (seq_len != '0);
  assign start_zero   = (state == S_IDLE) && start && (seq_len == '0);

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    nucl_fire = 1'b0;
    pop       = 1'b0;
    seq_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nx = S_RUN;
      end
      S_RUN: begin
        in_ready  = !fifo_full && (words_acc < words_needed);
        out_valid = !fifo_empty;
        if (!fifo_empty) begin
          out_char = nucl_ascii;
`ifndef NUCL_FASTA_WRAP_EN
          out_last = nucl_last;
`endif
        end
        if (out_valid && out_ready) begin
          nucl_fire = 1'b1;
          // Pop also on the final nucleotide so a partial word's tail is dropped.
          pop = nucl_last || (nib_idx == 4'hF);
`ifdef NUCL_FASTA_WRAP_EN
          if (nucl_last || (line_cnt == LINE_LAST)) state_nx = S_NL;
`else
          if (nucl_last) begin
            state_nx = S_IDLE;
            seq_end  = 1'b1;
          end
`endif
        end
      end
      S_NL: begin
        out_valid = 1'b1;
        out_char  = 8'h0A;
        out_last  = seq_complete;
        if (out_ready) begin
          state_nx = seq_complete ? S_IDLE : S_RUN;
          seq_end  = seq_complete;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign push = in_valid && in_ready;
  assign busy = (state != S_IDLE);
  assign done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len_q        <= '0;
      words_needed <= '0;
      words_acc    <= '0;
      nucl_cnt     <= '0;
      nib_idx      <= '0;
      done_q       <= 1'b0;
`ifdef NUCL_FASTA_WRAP_EN
      line_cnt     <= '0;
`endif
    end else begin
      done_q <= seq_end || start_zero;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (start_ok) begin
        len_q        <= seq_len;
        words_needed <= LEN_W'(seq_len[LEN_W-1:4]) + LEN_W'(|seq_len[3:0]);
        words_acc    <= '0;
        nucl_cnt     <= '0;
        nib_idx      <= '0;
`ifdef NUCL_FASTA_WRAP_EN
        line_cnt     <= '0;
`endif
      end else begin
        if (push) words_acc <= words_acc + LEN_W'(1);
        if (nucl_fire) begin
          nucl_cnt <= nucl_cnt + LEN_W'(1);
          nib_idx  <= pop ? 4'h0 : nib_idx + 4'h1;
`ifdef NUCL_FASTA_WRAP_EN
          line_cnt <= line_cnt + LEN_W'(1);
`endif
        end
`ifdef NUCL_FASTA_WRAP_EN
        if ((state == S_NL) && out_ready) line_cnt <= '0;
`endif
      end
    end
  end

  // Storage carries no reset; the pointers alone define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_nucl_ascii_serializer.sv
module tb_nucl_ascii_serializer;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef NUCL_FASTA_WRAP_EN
  localparam int LINE_LEN = 4;
`else
  localparam int LINE_LEN = 60;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] seq_len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_char;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             done;

  nucl_ascii_serializer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_W     (LEN_W),
    .LINE_LEN  (LINE_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seq_len  (seq_len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_char (out_char),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  exp_q[$];   // {last, char}
  logic [31:0] wq[$];
  int          cur_len;
  int          seq_nucl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_ascii(input logic [1:0] c);
    case (c)
      2'b00:   return 8'h41;
      2'b01:   return 8'h43;
      2'b10:   return 8'h47;
      default: return 8'h54;
    endcase
  endfunction

  task automatic model_word(input logic [31:0] w);
    logic fin;
    for (int i = 0; i < 16; i++) begin
      if (seq_nucl < cur_len) begin
        seq_nucl++;
        fin = (seq_nucl == cur_len);
`ifdef NUCL_FASTA_WRAP_EN
        exp_q.push_back({1'b0, to_ascii(w[31-2*i -: 2])});
        if ((seq_nucl % LINE_LEN) == 0 || fin) exp_q.push_back({fin, 8'h0A});
`else
        exp_q.push_back({fin, to_ascii(w[31-2*i -: 2])});
`endif
      end
    end
  endtask

  // Runs one sequence over the words in wq. stall: cycles of out_ready=0 at
  // the start; mid_start: pulse start during RUN; abort: return after that
  // many chars have been handed over.
  task automatic run_seq(input int len, input int stall, input bit mid_start, input int abort);
    int         acc = 0;
    int         got = 0;
    int         cyc = 0;
    bit         seen_done = 0;
    bit         lat_chk = 0;
    bit         ir_chk = 0;
    bit         held_v = 0;
    logic [7:0] held = '0;
    logic [8:0] e;
    cur_len  = len;
    seq_nucl = 0;
    exp_q.delete();
    @(negedge clk);
    start   = 1'b1;
    seq_len = LEN_W'(len);
    @(negedge clk);
    start   = 1'b0;
    seq_len = LEN_W'($urandom);
    chk("busy_after_start", busy, 1);
    while (!seen_done && cyc < 5000) begin
      if (done) begin
        seen_done = 1;
        chk("busy_at_done", busy, 0);
        chk("char_count", got, len);
        chk("exp_q_drained", exp_q.size(), 0);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
      end else begin
        if (lat_chk) begin
          chk("first_word_latency", out_valid, 1);
          lat_chk = 0;
        end
        if (acc > 0 && acc == wq.size() && !ir_chk) begin
          chk("in_ready_drop", in_ready, 0);
          ir_chk = 1;
        end
        if (stall > 0 && cyc < stall && out_valid) begin
          if (held_v) chk("stall_char_stable", out_char, held);
          held   = out_char;
          held_v = 1;
        end
        if (stall > 0 && cyc == stall - 1) begin
          chk("stall_in_ready", in_ready, 0);
          chk("stall_fifo_words", acc, FIFO_DEPTH);
        end
        out_ready = (cyc < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_char", {out_last, out_char}, 9'h000);
          end else begin
            e = exp_q.pop_front();
            chk("char", {23'd0, out_last, out_char}, {23'd0, e});
          end
          got++;
        end
        if (mid_start && cyc == 3) begin
          start   = 1'b1;
          seq_len = LEN_W'(5);
        end else begin
          start = 1'b0;
        end
        if (acc < wq.size()) begin
          in_valid = 1'b1;
          in_data  = wq[acc];
          if (in_ready) begin
            model_word(wq[acc]);
            if (acc == 0) lat_chk = 1;
            acc++;
          end
        end else begin
          in_valid = 1'b0;
          in_data  = $urandom;
        end
        if (abort > 0 && got == abort) return;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) chk("timeout_done", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    wq = '{32'h1B1B1B1B};
    run_seq(16, 0, 0, 0);

    wq = '{32'hFFFFFFFF, 32'h00FFFFFF};
    run_seq(20, 0, 0, 0);

    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    run_seq(128, 20, 0, 0);

    wq = '{32'h1B1B0000};
    run_seq(8, 0, 0, 0);

    wq = '{32'h12345678, 32'h9ABCDEF0};
    run_seq(17, 0, 0, 0);

    wq = '{32'hDEADBEEF, 32'h0F0F0F0F};
    run_seq(32, 0, 1, 0);

    // Asynchronous reset mid-sequence.
    wq = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    run_seq(32, 0, 0, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_char", out_char, 8'h00);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wq = '{32'hE4E4E4E4};
    run_seq(16, 0, 0, 0);

    // Zero-length sequence.
    @(negedge clk);
    start   = 1'b1;
    seq_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_len_done", done, 1);
    chk("zero_len_busy", busy, 0);
    chk("zero_len_out_valid", out_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_len_quiet", {done, out_valid}, 2'b00);
    end

    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    run_seq(45, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
